byte_lane_mem: RTL and testbench

- Parametrised successor to the team's fixed 32-bit little-endian byte memory.
- Byte-addressable single-port memory with configurable word width, depth and endianness.
- Supports byte/half/word/dword sub-word access with sign or zero extension, misalignment detection, and valid/ready handshakes on request and response.
- Sits between a core load/store unit and on-chip storage.

---
 rtl/byte_lane_mem.sv | 106 ++++++++++
 tb/tb_byte_lane_mem.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/byte_lane_mem.sv
// rtl/byte_lane_mem.sv - byte-addressable single-port memory with sub-word access, configurable endianness
// Requests are registered into a one-deep response stage; reads sample the array combinationally at acceptance.

module byte_lane_mem #(
    parameter int BYTES      = 4,
    parameter int ADDR_W     = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_we,
    input  logic [ADDR_W+$clog2(BYTES)-1:0]   req_addr,
    input  logic [1:0]                        req_size,
    input  logic                              req_signed,
    input  logic [8*BYTES-1:0]                req_wdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [8*BYTES-1:0]                rsp_data,
    output logic                              rsp_err
);

    localparam int OFF_W  = $clog2(BYTES);
    localparam int DATA_W = 8 * BYTES;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic [BYTES-1:0]  wr_be;
    logic              accept;
    logic              oversize;
    logic              misaligned;
    logic              req_err;
    logic              sign_bit;
    int                nbytes;
    int                off;

    assign word_idx  = req_addr[ADDR_W+OFF_W-1:OFF_W];
    assign rd_word   = mem[word_idx];
    assign req_ready = !rst && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        nbytes     = 1 << req_size;
        off        = int'(req_addr[OFF_W-1:0]);
        oversize   = nbytes > BYTES;
        misaligned = (off & (nbytes - 1)) != 0;
        req_err    = oversize || misaligned;
    end

    // Lane k of the operand maps to byte off+k of the word (LE) or is mirrored within the access (BE).
    always_comb begin
        wr_data  = '0;
        wr_be    = '0;
        rd_data  = '0;
        sign_bit = 1'b0;
        for (int k = 0; k < BYTES; k++) begin
            if (!oversize && (k < nbytes) && (off + k < BYTES)) begin
                wr_be[off+k]               = 1'b1;
                wr_data[8*(off+k) +: 8]    = req_wdata[8*(BIG_ENDIAN ? nbytes-1-k : k) +: 8];
                rd_data[8*(BIG_ENDIAN ? nbytes-1-k : k) +: 8] = rd_word[8*(off+k) +: 8];
            end
        end
        if (!oversize) begin
            sign_bit = rd_data[8*nbytes-1];
        end
        for (int r = 0; r < BYTES; r++) begin
            if (r >= nbytes) begin
                rd_data[8*r +: 8] = {8{req_signed && sign_bit}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= req_err;
            rsp_data  <= (req_we || req_err) ? '0 : rd_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // Storage is deliberately not reset; only accepted, error-free writes touch it.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int j = 0; j < BYTES; j++) begin
                if (wr_be[j]) begin
                    mem[word_idx][8*j +: 8] <= wr_data[8*j +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_lane_mem.sv
// tb/tb_byte_lane_mem.sv - directed table-driven bench for byte_lane_mem, LE and BE instances side by side

module tb_byte_lane_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready_le, rsp_valid_le, rsp_err_le;
    logic [31:0] rsp_data_le;
    logic        req_ready_be, rsp_valid_be, rsp_err_be;
    logic [31:0] rsp_data_be;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] exp_le;
        logic [31:0] exp_be;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    byte_lane_mem #(.BYTES(4), .ADDR_W(8), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_le),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_le), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_le), .rsp_err(rsp_err_le)
    );

    byte_lane_mem #(.BYTES(4), .ADDR_W(8), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_be),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_be), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_be), .rsp_err(rsp_err_be)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_req(input logic we, input logic [9:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        set_req(v.we, v.addr, v.size, v.sgn, v.wdata);
        rsp_ready = 1'b1;
        chk($sformatf("v%0d_req_ready_le", idx), {31'b0, req_ready_le}, 32'd1);
        chk($sformatf("v%0d_req_ready_be", idx), {31'b0, req_ready_be}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk($sformatf("v%0d_valid_le", idx), {31'b0, rsp_valid_le}, 32'd1);
        chk($sformatf("v%0d_valid_be", idx), {31'b0, rsp_valid_be}, 32'd1);
        chk($sformatf("v%0d_data_le", idx), rsp_data_le, v.exp_le);
        chk($sformatf("v%0d_data_be", idx), rsp_data_be, v.exp_be);
        chk($sformatf("v%0d_err_le", idx), {31'b0, rsp_err_le}, {31'b0, v.exp_err});
        chk($sformatf("v%0d_err_be", idx), {31'b0, rsp_err_be}, {31'b0, v.exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        set_req(1'b0, 10'h0, 2'd0, 1'b0, 32'h0);
        req_valid = 1'b0;

        //        we    addr     size  sgn   wdata          exp_le         exp_be         err
        vecs.push_back('{1'b1, 10'h010, 2'd2, 1'b0, 32'h11223344, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 10'h011, 2'd0, 1'b0, 32'h0,        32'h00000033, 32'h00000022, 1'b0});
        vecs.push_back('{1'b0, 10'h012, 2'd1, 1'b1, 32'h0,        32'h00001122, 32'h00003344, 1'b0});
        vecs.push_back('{1'b1, 10'h013, 2'd0, 1'b0, 32'h00000080, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 10'h013, 2'd0, 1'b1, 32'h0,        32'hFFFFFF80, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 10'h010, 2'd2, 1'b0, 32'h0,        32'h80223344, 32'h11223380, 1'b0});
        vecs.push_back('{1'b1, 10'h000, 2'd2, 1'b0, 32'h11223344, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 10'h000, 2'd0, 1'b0, 32'h0,        32'h00000044, 32'h00000011, 1'b0});
        vecs.push_back('{1'b0, 10'h002, 2'd1, 1'b0, 32'h0,        32'h00001122, 32'h00003344, 1'b0});
        vecs.push_back('{1'b1, 10'h001, 2'd1, 1'b0, 32'h0000BEEF, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 10'h000, 2'd2, 1'b0, 32'h0,        32'h11223344, 32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 10'h000, 2'd3, 1'b0, 32'h0,        32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 10'h016, 2'd1, 1'b0, 32'h0000A5F0, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 10'h016, 2'd1, 1'b1, 32'h0,        32'hFFFFA5F0, 32'hFFFFA5F0, 1'b0});
        vecs.push_back('{1'b0, 10'h016, 2'd1, 1'b0, 32'h0,        32'h0000A5F0, 32'h0000A5F0, 1'b0});
        vecs.push_back('{1'b0, 10'h017, 2'd0, 1'b1, 32'h0,        32'hFFFFFFA5, 32'hFFFFFFF0, 1'b0});
        vecs.push_back('{1'b0, 10'h010, 2'd2, 1'b1, 32'h0,        32'h80223344, 32'h11223380, 1'b0});
        vecs.push_back('{1'b0, 10'h012, 2'd2, 1'b0, 32'h0,        32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 10'h014, 2'd0, 1'b0, 32'h0000007F, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 10'h014, 2'd0, 1'b1, 32'h0,        32'h0000007F, 32'h0000007F, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, rsp_valid_le}, 32'd0);
        chk("rst_data", rsp_data_le, 32'd0);
        chk("rst_err", {31'b0, rsp_err_le}, 32'd0);
        chk("rst_ready", {31'b0, req_ready_le}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Backpressure: three reads, consumer stalls for three cycles after the first response.
        @(negedge clk);
        set_req(1'b0, 10'h010, 2'd2, 1'b0, 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        set_req(1'b0, 10'h000, 2'd2, 1'b0, 32'h0);
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_%0d", c), {31'b0, req_ready_le}, 32'd0);
            chk($sformatf("bp_valid_%0d", c), {31'b0, rsp_valid_le}, 32'd1);
            chk($sformatf("bp_hold_%0d", c), rsp_data_le, 32'h80223344);
            chk($sformatf("bp_hold_be_%0d", c), rsp_data_be, 32'h11223380);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_second", rsp_data_le, 32'h11223344);
        chk("bp_second_valid", {31'b0, rsp_valid_le}, 32'd1);
        set_req(1'b0, 10'h016, 2'd1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp_third", rsp_data_le, 32'h0000A5F0);
        chk("bp_third_be", rsp_data_be, 32'h0000A5F0);
        @(posedge clk);
        #1;
        chk("bp_drained", {31'b0, rsp_valid_le}, 32'd0);

        // Reset while a response is stalled; a request held during reset must be ignored.
        @(negedge clk);
        set_req(1'b0, 10'h000, 2'd2, 1'b0, 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rr_pending", {31'b0, rsp_valid_le}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rr_ready_in_rst", {31'b0, req_ready_le}, 32'd0);
        @(posedge clk);
        #1;
        chk("rr_valid", {31'b0, rsp_valid_le}, 32'd0);
        chk("rr_data", rsp_data_le, 32'd0);
        chk("rr_err", {31'b0, rsp_err_le}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rr_ignored", {31'b0, rsp_valid_le}, 32'd0);
        chk("rr_ignored_be", {31'b0, rsp_valid_be}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;

        run_vec('{1'b0, 10'h010, 2'd2, 1'b0, 32'h0, 32'h80223344, 32'h11223380, 1'b0}, 100);
        run_vec('{1'b0, 10'h000, 2'd2, 1'b0, 32'h0, 32'h11223344, 32'h11223344, 1'b0}, 101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
